// File: rtl/hsid_x_obi_mem_resp.sv
// OBI subordinate serving word reads/writes to the HSID-X pixel memory.
// Programmable grant stall and read latency; out-of-range word indices return err.
module hsid_x_obi_mem_resp #(
    parameter int WORD_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int MEM_DEPTH      = 2 ** MEM_ADDR_WIDTH,
    parameter int GNT_STALL      = 0,
    parameter int RD_LATENCY     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    output logic                    gnt,
    input  logic [31:0]             addr,
    input  logic                    we,
    input  logic [3:0]              be,
    input  logic [WORD_WIDTH-1:0]   wdata,
    output logic                    rvalid,
    output logic [WORD_WIDTH-1:0]   rdata,
    output logic                    err,
    output logic                    busy
);

    localparam int MAW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [MEM_ADDR_WIDTH:0] DEPTH_L = MEM_DEPTH[MEM_ADDR_WIDTH:0];
    localparam logic [2:0] STALL_LOAD = 3'(GNT_STALL - 1);

    typedef enum logic [1:0] {HXOR_IDLE, HXOR_STALL, HXOR_GRANT} state_t;

    typedef struct packed {
        logic                  vld;
        logic                  err;
        logic [WORD_WIDTH-1:0] data;
    } resp_t;

    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic gnt_c, accept, in_range;
    logic [MEM_ADDR_WIDTH-1:0] idx;
    logic [MAW-1:0] widx;
    logic [WORD_WIDTH-1:0] mem [2 ** MAW];
    resp_t resp_in;
    resp_t [RD_LATENCY-1:0] pipe;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic unused_addr;

    assign idx         = addr[MEM_ADDR_WIDTH+1:2];
    assign widx        = idx[MAW-1:0];
    assign in_range    = ({1'b0, idx} < DEPTH_L);
    assign unused_addr = ^{addr[31:MEM_ADDR_WIDTH+2], addr[1:0]};

    // Counter reaching 0 leaves STALL, so gnt rises exactly GNT_STALL cycles after req.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_c   = 1'b0;
        case (state)
            HXOR_IDLE: begin
                if (req) begin
                    if (GNT_STALL == 0) begin
                        gnt_c = 1'b1;
                    end else if (GNT_STALL == 1) begin
                        state_n = HXOR_GRANT;
                    end else begin
                        state_n = HXOR_STALL;
                        cnt_n   = STALL_LOAD;
                    end
                end
            end
            HXOR_STALL: begin
                if (!req) begin
                    state_n = HXOR_IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) state_n = HXOR_GRANT;
                end
            end
            HXOR_GRANT: begin
                state_n = HXOR_IDLE;
                cnt_n   = 3'd0;
                gnt_c   = req;
            end
            default: begin
                state_n = HXOR_IDLE;
                cnt_n   = 3'd0;
            end
        endcase
    end

    assign gnt    = gnt_c & rst_n;
    assign accept = req & gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HXOR_IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Memory holds its contents across reset.
    always_ff @(posedge clk) begin
        if (accept && we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        resp_in.vld  = accept;
        resp_in.err  = accept & ~in_range;
        resp_in.data = (accept && !we && in_range) ? mem[widx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= resp_in;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_comb begin
        vld_pipe = '0;
        for (int i = 0; i < RD_LATENCY; i++) vld_pipe[i] = pipe[i].vld;
    end

    assign rvalid = pipe[RD_LATENCY-1].vld;
    assign err    = pipe[RD_LATENCY-1].err;
    assign rdata  = pipe[RD_LATENCY-1].data;
    assign busy   = (|vld_pipe) | (state != HXOR_IDLE);

endmodule

// File: tb/tb_hsid_x_obi_mem_resp.sv
// Randomized bench for hsid_x_obi_mem_resp: two instances (no stall / stalled grant)
// checked against a cycle-level transaction model with queued expected responses.
module tb_hsid_x_obi_mem_resp;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, req, we;
    logic [1:0][31:0] addr, wdata;
    logic [1:0][3:0]  be;
    wire  [1:0]       gnt, rvalid, err, busy;
    wire  [1:0][31:0] rdata;

    hsid_x_obi_mem_resp #(.MEM_DEPTH(DEPTH), .GNT_STALL(0), .RD_LATENCY(3)) u_fast (
        .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .gnt(gnt[0]), .addr(addr[0]),
        .we(we[0]), .be(be[0]), .wdata(wdata[0]), .rvalid(rvalid[0]),
        .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));

    hsid_x_obi_mem_resp #(.MEM_DEPTH(DEPTH), .GNT_STALL(3), .RD_LATENCY(2)) u_slow (
        .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .gnt(gnt[1]), .addr(addr[1]),
        .we(we[1]), .be(be[1]), .wdata(wdata[1]), .rvalid(rvalid[1]),
        .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));

    function automatic int gs(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int rl(input int d);
        return (d == 0) ? 3 : 2;
    endfunction

    typedef struct {
        int          due;
        logic        e;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [2][DEPTH];
    int          cyc, start, n_cmp, n_bad;
    bit          pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Checks one cycle against the model, then applies an expected acceptance.
    task automatic sample(input int d);
        logic eg, rv, inr;
        int   idx;
        exp_t e;
        @(negedge clk);
        eg = req[d] && (cyc - start >= gs(d));
        chk("gnt", {31'b0, gnt[d]}, {31'b0, eg});
        chk("busy", {31'b0, busy[d]},
            {31'b0, (q.size() > 0) || (gs(d) > 0 && req[d] && cyc > start)});
        rv = (q.size() > 0) && (q[0].due == cyc);
        chk("rvalid", {31'b0, rvalid[d]}, {31'b0, rv});
        if (rv) begin
            e = q.pop_front();
            chk("rdata", rdata[d], e.data);
            chk("err", {31'b0, err[d]}, {31'b0, e.e});
        end
        if (eg) begin
            idx = int'(addr[d][14:2]);
            inr = (idx < DEPTH);
            e.due = cyc + rl(d);
            e.e   = ~inr;
            e.data = 32'h0;
            if (we[d]) begin
                if (inr) begin
                    for (int b = 0; b < 4; b++)
                        if (be[d][b]) mm[d][idx][8*b +: 8] = wdata[d][8*b +: 8];
                end
            end else if (inr) begin
                e.data = mm[d][idx];
            end
            q.push_back(e);
            pending = 1'b0;
        end
    endtask

    task automatic set_fields(input int d, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] dat);
        we[d] = w; addr[d] = a; be[d] = b; wdata[d] = dat;
    endtask

    function automatic logic [31:0] rand_addr();
        int r, idx;
        r = $urandom_range(0, 9);
        if (r < 7)       idx = $urandom_range(0, 15);
        else if (r < 9)  idx = $urandom_range(0, DEPTH - 1);
        else if ($urandom_range(0, 1) == 0) idx = $urandom_range(DEPTH, DEPTH + 8);
        else             idx = 8191;
        return {17'b0, idx[12:0], 2'($urandom_range(0, 3))};
    endfunction

    task automatic set_random(input int d);
        set_fields(d, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic wait_accept(input int d);
        for (int k = 0; k < 16 && pending; k++) begin
            tick();
            sample(d);
        end
        chk("accept_timeout", {31'b0, pending}, 32'h0);
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] dat);
        tick();
        set_fields(d, w, a, b, dat);
        req[d] = 1'b1; pending = 1'b1; start = cyc;
        sample(d);
        if (pending) wait_accept(d);
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            tick();
            req[d] = 1'b0;
            sample(d);
        end
    endtask

    task automatic random_phase(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (!pending) begin
                if ($urandom_range(0, 3) != 0) begin
                    set_random(d);
                    req[d] = 1'b1; pending = 1'b1; start = cyc;
                end else begin
                    req[d] = 1'b0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                set_random(d);
            end
            sample(d);
        end
        if (pending) wait_accept(d);
        idle(d, rl(d) + 1);
    endtask

    // One cycle of rst_n low; everything in flight is forgotten.
    task automatic reset_cycle(input int d);
        tick();
        rst_n[d] = 1'b0;
        req[d]   = 1'b0;
        @(negedge clk);
        q.delete();
        pending = 1'b0;
        tick();
        rst_n[d] = 1'b1;
        sample(d);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; start = 0; pending = 1'b0;
        rst_n = 2'b00; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
        repeat (2) tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt", {31'b0, gnt[d]}, 32'h0);
            chk("rst_rvalid", {31'b0, rvalid[d]}, 32'h0);
            chk("rst_rdata", rdata[d], 32'h0);
            chk("rst_err", {31'b0, err[d]}, 32'h0);
            chk("rst_busy", {31'b0, busy[d]}, 32'h0);
        end
        tick();
        rst_n = 2'b11;

        for (int d = 0; d < 2; d++) begin
            q.delete();
            pending = 1'b0;
            for (int w = 0; w < DEPTH; w++) xfer(d, 1'b1, 32'(w * 4), 4'hF, $urandom);
            // back-to-back write/read, then byte-lane merge
            xfer(d, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
            xfer(d, 1'b0, 32'h10, 4'h0, 32'h0);
            xfer(d, 1'b1, 32'h10, 4'b0101, 32'h11223344);
            xfer(d, 1'b0, 32'h10, 4'h0, 32'h0);
            idle(d, rl(d) + 1);
            // out of range: word 64 errors, write dropped, word 0 intact
            xfer(d, 1'b0, 32'h100, 4'h0, 32'h0);
            xfer(d, 1'b1, 32'h100, 4'hF, 32'hCAFEF00D);
            xfer(d, 1'b0, 32'h0, 4'h0, 32'h0);
            idle(d, rl(d) + 1);
            // pipelined reads of words 0..3 preloaded with their index
            for (int w = 0; w < 4; w++) xfer(d, 1'b1, 32'(w * 4), 4'hF, 32'(w));
            for (int w = 0; w < 4; w++) xfer(d, 1'b0, 32'(w * 4), 4'h0, 32'h0);
            idle(d, rl(d) + 1);
            random_phase(d, 300);
            // reset with a read in flight, then with a request pending
            xfer(d, 1'b0, 32'h10, 4'h0, 32'h0);
            reset_cycle(d);
            idle(d, rl(d) + 2);
            tick();
            set_fields(d, 1'b0, 32'h14, 4'h0, 32'h0);
            req[d] = 1'b1; pending = 1'b1; start = cyc;
            sample(d);
            reset_cycle(d);
            idle(d, rl(d) + 2);
            xfer(d, 1'b0, 32'h10, 4'h0, 32'h0);
            xfer(d, 1'b0, 32'h14, 4'h0, 32'h0);
            idle(d, rl(d) + 1);
            chk("queue_drained", 32'(q.size()), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
